// File: rtl/wave_capture_pkg.sv
// Shared types and helpers for the wave capture writer.
// Sample width, buffer depth and offset-binary conversion live here.
package wave_capture_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 256;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Two's complement to offset binary, keeping the top byte.
    function automatic logic [DATA_W-1:0] to_offset(
        input logic [SAMPLE_W-1:0] s
    );
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: DATA_W-1]};
    endfunction

endpackage

// File: rtl/wave_capture_writer_zero_cross_detect.sv
// Positive-going zero crossing detector on the sample stream.
// Remembers the sign of the last strobed sample.
module zero_cross_detect
    import wave_capture_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic new_sample_ready,
    input  logic sample_msb,
    output logic crossing
);

    logic prev_neg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_neg <= 1'b0;
        end else if (new_sample_ready) begin
            prev_neg <= sample_msb;
        end
    end

    assign crossing = new_sample_ready & prev_neg & ~sample_msb;

endmodule

// File: rtl/wave_capture_writer.sv
// Writes 256-sample captures into the half of the sample RAM
// that the wave display is not reading, then flips halves.
module wave_capture_writer
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_W,
    parameter int ADDR_WIDTH   = ADDR_W,
    parameter int DATA_WIDTH   = DATA_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic                    write_enable,
    output logic [DATA_WIDTH-1:0]   write_sample,
    output logic                    read_index
);

    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic             crossing;

    zero_cross_detect u_zcd (
        .clk              (clk),
        .reset_n          (reset_n),
        .new_sample_ready (new_sample_ready),
        .sample_msb       (new_sample_in[SAMPLE_WIDTH-1]),
        .crossing         (crossing)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ARMED;
            index         <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            write_enable <= 1'b0;
            unique case (state)
                ARMED: begin
                    if (crossing) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, index};
                        write_sample  <= to_offset(new_sample_in);
                        index         <= index + 1'b1;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (new_sample_ready) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, index};
                        write_sample  <= to_offset(new_sample_in);
                        index         <= index + 1'b1;
                        if (index == LAST_IDX) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Flip only once the display has let go of its half.
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        state      <= ARMED;
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture_writer.sv
// Directed and randomized bench for wave_capture_writer.
// A fill-count model predicts every RAM write and buffer flip.
module tb_wave_capture_writer;

    logic        clk;
    logic        reset_n;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int n_tests;
    int n_fail;

    // Model: samples stored so far in the current fill, and flip wait.
    int m_count;
    bit m_waiting;
    bit m_half;
    bit m_prev_neg;

    wave_capture_writer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count    = 0;
        m_waiting  = 0;
        m_half     = 0;
        m_prev_neg = 0;
    endtask

    task automatic step(input bit rdy, input int s, input bit idle);
        bit         exp_we;
        logic [8:0] exp_addr;
        logic [7:0] exp_data;
        logic [15:0] sv;
        sv = 16'(s);
        @(negedge clk);
        new_sample_ready  = rdy;
        new_sample_in     = sv;
        wave_display_idle = idle;
        @(posedge clk);
        #1;
        exp_we   = 0;
        exp_addr = '0;
        exp_data = '0;
        if (m_waiting) begin
            if (idle) begin
                m_half    = ~m_half;
                m_waiting = 0;
            end
        end else if (rdy && (m_count > 0 || (m_prev_neg && s >= 0))) begin
            exp_we   = 1;
            exp_addr = {~m_half, 8'(m_count)};
            exp_data = 8'((s + 32768) / 256);
            m_count++;
            if (m_count == 256) begin
                m_count   = 0;
                m_waiting = 1;
            end
        end
        if (rdy) m_prev_neg = (s < 0);
        check("we", 32'(write_enable), 32'(exp_we));
        check("read_index", 32'(read_index), 32'(m_half));
        if (exp_we) begin
            check("addr", 32'(write_address), 32'(exp_addr));
            check("data", 32'(write_sample), 32'(exp_data));
        end
    endtask

    task automatic feed(input int s);
        step(1, s, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_we"}, 32'(write_enable), 0);
        check({tag, "_addr"}, 32'(write_address), 0);
        check({tag, "_data"}, 32'(write_sample), 0);
        check({tag, "_ri"}, 32'(read_index), 0);
    endtask

    int s_rand;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        reset_n           = 1'b0;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: positive samples while armed cause no write
        feed(5);
        step(0, 0, 0);
        feed(7);
        check("t1_we", 32'(write_enable), 0);

        // 2: crossing starts fill at 0x100
        feed(-3);
        feed(2);
        check("t2_addr", 32'(write_address), 32'h100);
        check("t2_data", 32'(write_sample), 32'h80);
        for (int i = 1; i < 256; i++) feed(int'($urandom_range(0, 65535)) - 32768);
        check("t2_last", 32'(write_address), 32'h1FF);
        feed(-5);
        feed(5);
        check("t2_wait", 32'(write_enable), 0);

        // 3: idle in WAIT flips the read half
        step(0, 0, 1);
        check("t3_ri", 32'(read_index), 1);
        feed(-1);
        feed(1);
        check("t3_addr", 32'(write_address), 32'h000);
        for (int i = 1; i < 256; i++) feed(int'($urandom_range(0, 65535)) - 32768);
        check("t3_last", 32'(write_address), 32'h0FF);
        step(1, 100, 1);
        check("t3_ri2", 32'(read_index), 0);

        // 4: offset-binary extremes
        feed(-1);
        feed(32767);
        check("t4_max", 32'(write_sample), 32'hFF);
        feed(-32768);
        check("t4_min", 32'(write_sample), 32'h00);
        feed(-256);
        check("t4_m256", 32'(write_sample), 32'h7F);

        // 5: asynchronous reset mid-fill
        for (int i = 4; i < 100; i++) feed(int'($urandom_range(0, 65535)) - 32768);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_cleared("t5");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        feed(-9);
        feed(9);
        check("t5_addr", 32'(write_address), 32'h100);

        // 6: idle held high outside WAIT is ignored
        for (int i = 1; i < 256; i++) step(1, int'($urandom_range(0, 65535)) - 32768, 1);
        check("t6_pre", 32'(read_index), 0);
        step(0, 0, 1);
        check("t6_flip", 32'(read_index), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        check("t6_once", 32'(read_index), 1);

        // randomized traffic, with ready and idle sometimes coinciding
        for (int i = 0; i < 4000; i++) begin
            s_rand = int'($urandom_range(0, 65535)) - 32768;
            step(bit'($urandom_range(0, 1)), s_rand,
                 $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
